grid_slot_operand_join: RTL and testbench

Parametrised operand staging and join unit for a reconfigurable grid slot. Each of `N_IN` input channels buffers operands arriving at independent rates in its own first-word-fall-through FIFO, with upstream valid/ready backpressure. Any channel can instead be replaced by a configured constant. The block presents one aligned operand vector to the slot's operation unit and pops all used channels atomically on acknowledge. It replaces the fixed two-input, unbounded-push slot front end and adds backpressure, constants, flush and overflow detection.

---
 rtl/grid_slot_operand_join.sv | 95 +++++++++
 tb/tb_grid_slot_operand_join.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_slot_operand_join.sv
// Operand staging and join for a grid slot: one FWFT FIFO per input channel,
// optional per-channel constants, and an atomic pop of all masked channels on fire.
module grid_slot_operand_join #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  input  logic [N_IN-1:0]         cfg_mask,
  input  logic [N_IN*WIDTH-1:0]   cfg_const,
  input  logic                    flush,
  output logic [N_IN*WIDTH-1:0]   op_data,
  output logic                    op_valid,
  input  logic                    op_ack,
  output logic [N_IN*CW-1:0]      occupancy,
  output logic                    overflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0]           mem_q [N_IN][DEPTH];
  logic [N_IN-1:0][PW-1:0]    wptr_q, wptr_d;
  logic [N_IN-1:0][PW-1:0]    rptr_q, rptr_d;
  logic [N_IN-1:0][CW-1:0]    cnt_q, cnt_d;
  logic                       overflow_q, overflow_d;
  logic [N_IN-1:0]            push, pop;
  logic                       all_ok, fire;

  // Ready and valid come only from registered counts and the mask.
  always_comb begin
    in_ready  = '0;
    op_data   = '0;
    occupancy = '0;
    all_ok    = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = cfg_mask[i] && (cnt_q[i] < CW'(DEPTH));
      if (cfg_mask[i] && (cnt_q[i] == '0)) all_ok = 1'b0;
      op_data[i*WIDTH +: WIDTH] = cfg_mask[i] ? mem_q[i][rptr_q[i]]
                                              : cfg_const[i*WIDTH +: WIDTH];
      occupancy[i*CW +: CW] = cnt_q[i];
    end
    op_valid = (|cfg_mask) && all_ok;
  end

  assign fire         = op_valid && op_ack;
  assign push         = in_valid & in_ready;
  assign pop          = fire ? cfg_mask : '0;
  assign overflow_err = overflow_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (|(in_valid & ~in_ready));
    for (int i = 0; i < N_IN; i++) begin
      wptr_d[i] = wptr_q[i] + PW'(push[i]);
      rptr_d[i] = rptr_q[i] + PW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    // Flush wins over any same-cycle push, pop or overflow.
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (push[i] && !flush) mem_q[i][wptr_q[i]] <= in_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_grid_slot_operand_join.sv
// Self-checking bench for grid_slot_operand_join: directed sequences, a vector
// table, and randomized traffic against a queue-based reference model.
module tb_grid_slot_operand_join;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data, cfg_const, op_data;
  logic [N-1:0]   in_valid, in_ready, cfg_mask;
  logic           flush, op_valid, op_ack, overflow_err;
  logic [N*CW-1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grid_slot_operand_join #(
    .WIDTH(W),
    .N_IN (N),
    .DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cfg_mask    (cfg_mask),
    .cfg_const   (cfg_const),
    .flush       (flush),
    .op_data     (op_data),
    .op_valid    (op_valid),
    .op_ack      (op_ack),
    .occupancy   (occupancy),
    .overflow_err(overflow_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] occ(input int i);
    return occupancy[i*CW +: CW];
  endfunction

  task automatic idle();
    in_valid = '0;
    op_ack   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ack;
    logic        fl;
    logic [1:0]  e_ready;
    logic        e_valid;
    logic [63:0] e_data;
    logic [2:0]  e_occ0;
    logic [2:0]  e_occ1;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one queue per channel.
  logic [31:0] mq [N][$];
  logic        m_ovf;

  localparam logic [31:0] C0 = 32'hC0C0_C0C0;
  localparam logic [31:0] C1 = 32'hDEAD_BEEF;

  initial begin
    int fires;
    int maxocc;
    logic [N-1:0] e_ready;
    logic         e_valid;

    // Reset held with pushes driven.
    rst       = 1'b0;
    cfg_mask  = 2'b11;
    cfg_const = {C1, C0};
    in_valid  = 2'b11;
    in_data   = {32'h5555_5555, 32'h4444_4444};
    op_ack    = 1'b1;
    flush     = 1'b0;
    repeat (2) tick();
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_valid", 64'(op_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'b11);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    cfg_mask = 2'b01;
    #1;
    check("rst_const_slice", 64'(op_data[63:32]), 64'(C1));
    check("rst_ready_mask", 64'(in_ready), 64'b01);
    cfg_mask = 2'b11;
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // First join: ch0 alone is not enough.
    in_valid = 2'b01;
    in_data  = {32'h0, 32'h11};
    tick();
    idle();
    check("join_wait_ch1", 64'(op_valid), 64'd0);
    check("join_occ0", 64'(occ(0)), 64'd1);
    in_valid = 2'b10;
    in_data  = {32'h22, 32'h0};
    #1;
    check("join_no_bypass", 64'(op_valid), 64'd0);
    tick();
    idle();
    check("join_valid", 64'(op_valid), 64'd1);
    check("join_data", 64'(op_data), {32'h22, 32'h11});
    op_ack = 1'b1;
    tick();
    idle();
    check("join_popped", 64'(occupancy), 64'd0);

    // Vector table, starting from empty queues and a clear flag.
    tbl.push_back('{2'b11, 2'b11, 32'h33, 32'h44, 1'b0, 1'b0, 2'b11, 1'b1, {32'h44, 32'h33}, 3'd1, 3'd1, 1'b0});
    tbl.push_back('{2'b11, 2'b01, 32'h55, 32'h0,  1'b1, 1'b0, 2'b11, 1'b0, 64'h0,            3'd1, 3'd0, 1'b0});
    tbl.push_back('{2'b01, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0, 2'b01, 1'b1, {C1, 32'h55},     3'd1, 3'd0, 1'b0});
    tbl.push_back('{2'b01, 2'b10, 32'h0,  32'h99, 1'b0, 1'b0, 2'b01, 1'b1, {C1, 32'h55},     3'd1, 3'd0, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0, 2'b01, 1'b0, {C1, 32'h0},      3'd0, 3'd0, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0, 2'b00, 1'b0, {C1, C0},         3'd0, 3'd0, 1'b1});
    tbl.push_back('{2'b11, 2'b11, 32'h66, 32'h77, 1'b0, 1'b1, 2'b11, 1'b0, 64'h0,            3'd0, 3'd0, 1'b0});
    tbl.push_back('{2'b10, 2'b10, 32'h0,  32'h88, 1'b0, 1'b0, 2'b10, 1'b1, {32'h88, C0},     3'd0, 3'd1, 1'b0});
    tbl.push_back('{2'b11, 2'b01, 32'hAA, 32'h0,  1'b1, 1'b0, 2'b11, 1'b1, {32'h88, 32'hAA}, 3'd1, 3'd1, 1'b0});
    tbl.push_back('{2'b11, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0, 2'b11, 1'b0, 64'h0,            3'd0, 3'd0, 1'b0});
    foreach (tbl[k]) begin
      cfg_mask = tbl[k].mask;
      in_valid = tbl[k].valid;
      in_data  = {tbl[k].d1, tbl[k].d0};
      op_ack   = tbl[k].ack;
      flush    = tbl[k].fl;
      tick();
      idle();
      check($sformatf("tbl%0d_ready", k), 64'(in_ready), 64'(tbl[k].e_ready));
      check($sformatf("tbl%0d_valid", k), 64'(op_valid), 64'(tbl[k].e_valid));
      check($sformatf("tbl%0d_occ0", k), 64'(occ(0)), 64'(tbl[k].e_occ0));
      check($sformatf("tbl%0d_occ1", k), 64'(occ(1)), 64'(tbl[k].e_occ1));
      check($sformatf("tbl%0d_ovf", k), 64'(overflow_err), 64'(tbl[k].e_ovf));
      for (int i = 0; i < N; i++) begin
        if (!tbl[k].mask[i] || tbl[k].e_valid)
          check($sformatf("tbl%0d_data%0d", k, i), 64'(op_data[i*W +: W]),
                64'(tbl[k].e_data[i*W +: W]));
      end
    end

    // Full channel and sticky overflow.
    cfg_mask = 2'b11;
    for (int k = 0; k < 5; k++) begin
      in_valid = 2'b01;
      in_data  = {32'h0, 32'h100 + 32'(k)};
      #1;
      if (k == 4) check("full_ready", 64'(in_ready[0]), 64'd0);
      tick();
    end
    idle();
    check("full_occ", 64'(occ(0)), 64'd4);
    check("full_ovf", 64'(overflow_err), 64'd1);
    tick();
    check("full_ovf_sticky", 64'(overflow_err), 64'd1);
    cfg_mask = 2'b01;
    op_ack   = 1'b1;
    #1;
    check("full_head", 64'(op_data[31:0]), 64'h100);
    tick();
    idle();
    check("full_ready_after_pop", 64'(in_ready[0]), 64'd1);
    check("full_occ_after_pop", 64'(occ(0)), 64'd3);
    check("full_next_head", 64'(op_data[31:0]), 64'h101);
    flush = 1'b1;
    tick();
    idle();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_ovf", 64'(overflow_err), 64'd0);
    check("flush_valid", 64'(op_valid), 64'd0);

    // Skewed rates with ack held.
    cfg_mask = 2'b11;
    op_ack   = 1'b1;
    fires    = 0;
    maxocc   = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid[0] = (c < 4);
      in_valid[1] = (c % 3 == 0) && (c < 12);
      in_data     = {32'hA, 32'(c + 1)};
      #1;
      if (op_valid) begin
        fires++;
        check("skew_pair", 64'(op_data), {32'hA, 32'(fires)});
      end
      if (int'(occ(0)) > maxocc) maxocc = int'(occ(0));
      tick();
    end
    idle();
    check("skew_fires", 64'(fires), 64'd4);
    check("skew_peak_le_depth", 64'(maxocc <= D), 64'd1);
    check("skew_drained", 64'(occupancy), 64'd0);

    // Single-channel streaming with pointer wrap.
    cfg_mask = 2'b01;
    for (int k = 0; k < 12; k++) begin
      in_valid = 2'b01;
      in_data  = {32'h0, 32'(k)};
      op_ack   = (k > 0);
      #1;
      if (k > 0) begin
        check("wrap_valid", 64'(op_valid), 64'd1);
        check("wrap_data", 64'(op_data[31:0]), 64'(k - 1));
        check("wrap_occ", 64'(occ(0)), 64'd1);
      end
      tick();
    end
    idle();
    check("wrap_last", 64'(op_data[31:0]), 64'd11);
    op_ack = 1'b1;
    tick();
    idle();
    check("wrap_empty", 64'(occ(0)), 64'd0);

    // Flush beats a same-cycle push and fire.
    cfg_mask = 2'b11;
    in_valid = 2'b11; in_data = {32'h201, 32'h101}; tick();
    in_valid = 2'b11; in_data = {32'h202, 32'h102}; tick();
    in_valid = 2'b10; in_data = {32'h203, 32'h0};   tick();
    idle();
    check("fp_occ0", 64'(occ(0)), 64'd2);
    check("fp_occ1", 64'(occ(1)), 64'd3);
    in_valid = 2'b11;
    in_data  = {32'h2FF, 32'h1FF};
    op_ack   = 1'b1;
    flush    = 1'b1;
    tick();
    idle();
    check("fp_occ", 64'(occupancy), 64'd0);
    check("fp_valid", 64'(op_valid), 64'd0);
    in_valid = 2'b11;
    in_data  = {32'h301, 32'h300};
    tick();
    idle();
    check("fp_fresh", 64'(op_data), {32'h301, 32'h300});
    flush = 1'b1;
    tick();
    idle();

    // Randomized traffic against the queue model.
    for (int i = 0; i < N; i++) mq[i].delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) cfg_mask = N'($urandom_range(0, 3));
      in_valid = N'($urandom_range(0, 3));
      in_data  = {$urandom(), $urandom()};
      op_ack   = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 63) == 0);
      #1;
      e_valid = (cfg_mask != '0);
      for (int i = 0; i < N; i++) begin
        e_ready[i] = cfg_mask[i] && (mq[i].size() < D);
        if (cfg_mask[i] && mq[i].size() == 0) e_valid = 1'b0;
      end
      check("rnd_ready", 64'(in_ready), 64'(e_ready));
      check("rnd_valid", 64'(op_valid), 64'(e_valid));
      check("rnd_ovf", 64'(overflow_err), 64'(m_ovf));
      for (int i = 0; i < N; i++) begin
        check("rnd_occ", 64'(occ(i)), 64'(mq[i].size()));
        if (!cfg_mask[i])
          check("rnd_const", 64'(op_data[i*W +: W]), 64'(cfg_const[i*W +: W]));
        else if (mq[i].size() != 0)
          check("rnd_head", 64'(op_data[i*W +: W]), 64'(mq[i][0]));
      end
      if (flush) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        m_ovf = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (e_valid && op_ack && cfg_mask[i]) void'(mq[i].pop_front());
          if (in_valid[i] && e_ready[i]) mq[i].push_back(in_data[i*W +: W]);
          else if (in_valid[i]) m_ovf = 1'b1;
        end
      end
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
